dot_seq: RTL and testbench
==========================

DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 Parameter LEN_W, default 8: width of the element-count input.
REQ-002 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: begin a dot-product job; sampled only in IDLE.
REQ-005 Port len, input, LEN_W: element count, sampled with start.
REQ-006 Port op_valid, input, 1: operand pair a_data/b_data is valid.
REQ-007 Port op_ready, output, 1: block accepts an operand pair this cycle.
REQ-008 Port a_data, input, 16: operand A.
REQ-009 Port b_data, input, 16: operand B.
REQ-010 Port alu_in1, output, 16: ALU first operand.
REQ-011 Port alu_in2, output, 16: ALU second operand.
REQ-012 Port alu_op, output, 3: ALU opcode.
REQ-013 Port alu_out, input, 16: ALU combinational result.
REQ-014 Port alu_z, input, 1: ALU zero flag for alu_out.
REQ-015 Port result, output, 16: final dot product, registered.
REQ-016 Port result_z, output, 1: result == 0, registered.
REQ-017 Port done, output, 1: one-cycle pulse; result/result_z valid.
REQ-018 Port busy, output, 1: high in every state except IDLE.

Function
REQ-019 FSM states SHALL be IDLE, FETCH, MUL, ADD, DONE.
REQ-020 IDLE: start=1, len!=0 -> FETCH, load cnt=len, acc=0; start=1, len=0 -> DONE, load result=0, result_z=1; else stay.
REQ-021 FETCH: op_ready=1; op_valid=1 latches a_data/b_data and -> MUL; op_valid=0 stays, with no state change.
REQ-022 MUL: alu_op=2 (mul), alu_in1=A, alu_in2=B; prod <= alu_out; -> ADD.
REQ-023 ADD: alu_op=0 (add), alu_in1=prod, alu_in2=acc; acc <= alu_out; cnt <= cnt-1; if cnt==1 also result <= alu_out, result_z <= alu_z, -> DONE; else -> FETCH.
REQ-024 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-025 IDLE/FETCH/DONE: alu_op=4 (pass), alu_in1=alu_in2=0.
REQ-026 op_ready SHALL be 1 only in FETCH.
REQ-027 Arithmetic SHALL be modulo 2^16 (products and sums truncated, no saturation).
REQ-028 Latency with op_valid held high: done asserted 1+3*len cycles after the start cycle; len=0 gives 1 cycle.
REQ-029 start while busy SHALL be ignored.
REQ-030 result/result_z SHALL hold their value until the next job's final ADD.

Reset
REQ-031 reset SHALL force IDLE and clear cnt, acc, prod, A, B, result to 0, result_z=0, done=0, op_ready=0, busy=0.
REQ-032 reset asserted mid-job SHALL discard the job; no done pulse follows.

Configuration
REQ-033 With DOT_SEQ_ABORT_EN defined, input port abort (1 bit) SHALL be present; abort=1 in any non-IDLE state -> IDLE next cycle, result unchanged, no done pulse.
REQ-034 Without DOT_SEQ_ABORT_EN, the abort port SHALL be absent and jobs run to completion.
REQ-035 abort and reset asserted together SHALL behave as reset.

Structure
REQ-036 Shared package SHALL hold the ALU opcode constants (ADD=0, SUB=1, MUL=2, DIV=3, PASS=4) and the FSM state encoding.
REQ-037 No sub-module; the block SHALL connect externally to the existing ALU.

Verification
REQ-038 len=3, pairs (1,2),(3,4),(5,6), op_valid constant -> result=44, result_z=0, done at start+10.
REQ-039 len=0 -> done at start+1, result=0, result_z=1, op_ready never high.
REQ-040 len=1, pair (256,256) -> result=0 (wrap), result_z=1.
REQ-041 len=2, (7,3),(2,5); op_valid low 5 cycles before second pair -> result=31, done at start+12.
REQ-042 reset asserted in ADD of element 2 of a len=4 job -> IDLE next cycle, busy=0, no done; a following len=1 job (4,4) gives 16.
REQ-043 DOT_SEQ_ABORT_EN: abort during MUL -> IDLE next cycle, prior result retained, no done.

Source files
------------

// File: rtl/dot_seq_pkg.sv
// Shared definitions for the dot-product sequencer: ALU opcodes and FSM state encoding.
package dot_seq_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_DIV  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_PASS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MUL   = 3'd2,
        S_ADD   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/dot_seq.sv
// dot_seq: sequences an external ALU through multiply/accumulate steps to form
// the dot product of len operand pairs (all arithmetic modulo 2^16).
// Optional feature macro DOT_SEQ_ABORT_EN adds an abort input that drops the
// current job and returns to IDLE without a done pulse.
// The latched operands A/B and the product are held directly in the registered
// ALU operand outputs, so every output is driven from a flop.
module dot_seq
    import dot_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [DATA_W-1:0]   a_data,
    input  logic [DATA_W-1:0]   b_data,
    output logic [DATA_W-1:0]   alu_in1,
    output logic [DATA_W-1:0]   alu_in2,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic                alu_z,
    output logic [DATA_W-1:0]   result,
    output logic                result_z,
    output logic                done,
    output logic                busy
`ifdef DOT_SEQ_ABORT_EN
    ,
    input  logic                abort
`endif
);

    state_t             state;
    logic [LEN_W-1:0]   cnt;
    logic [DATA_W-1:0]  acc;
    logic               abort_hit;

    // Abort only matters while a job is in flight.
`ifdef DOT_SEQ_ABORT_EN
    assign abort_hit = abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // FSM with registered outputs; outputs are loaded for the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            alu_in1  <= '0;
            alu_in2  <= '0;
            alu_op   <= ALU_PASS;
            result   <= '0;
            result_z <= 1'b0;
            done     <= 1'b0;
            op_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_hit) begin
                state    <= S_IDLE;
                op_ready <= 1'b0;
                busy     <= 1'b0;
                alu_op   <= ALU_PASS;
                alu_in1  <= '0;
                alu_in2  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (len != '0) begin
                                state    <= S_FETCH;
                                cnt      <= len;
                                acc      <= '0;
                                op_ready <= 1'b1;
                            end else begin
                                state    <= S_DONE;
                                result   <= '0;
                                result_z <= 1'b1;
                                done     <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (op_valid) begin
                            state    <= S_MUL;
                            op_ready <= 1'b0;
                            alu_op   <= ALU_MUL;
                            alu_in1  <= a_data;
                            alu_in2  <= b_data;
                        end
                    end
                    S_MUL: begin
                        state   <= S_ADD;
                        alu_op  <= ALU_ADD;
                        alu_in1 <= alu_out;
                        alu_in2 <= acc;
                    end
                    S_ADD: begin
                        acc     <= alu_out;
                        cnt     <= cnt - LEN_W'(1);
                        alu_op  <= ALU_PASS;
                        alu_in1 <= '0;
                        alu_in2 <= '0;
                        if (cnt == LEN_W'(1)) begin
                            state    <= S_DONE;
                            result   <= alu_out;
                            result_z <= alu_z;
                            done     <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            op_ready <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        op_ready <= 1'b0;
                        busy     <= 1'b0;
                        alu_op   <= ALU_PASS;
                        alu_in1  <= '0;
                        alu_in2  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dot_seq.sv
// Bench for dot_seq: table of jobs with a result scoreboard, plus hand-written
// reset-mid-job and (when DOT_SEQ_ABORT_EN is defined) abort sequences.
module tb_dot_seq;
    import dot_seq_pkg::*;

    localparam int LEN_W   = 8;
    localparam int TIMEOUT = 200;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [LEN_W-1:0]    len;
    logic                op_valid;
    logic                op_ready;
    logic [15:0]         a_data, b_data;
    logic [15:0]         alu_in1, alu_in2, alu_out;
    logic [2:0]          alu_op;
    logic                alu_z;
    logic [15:0]         result;
    logic                result_z, done, busy;
`ifdef DOT_SEQ_ABORT_EN
    logic                abort;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int                len;
        logic [3:0][15:0]  a;
        logic [3:0][15:0]  b;
        int                gap_idx;
        int                gap_len;
        bit                spam;
        logic [15:0]       exp_res;
        logic              exp_z;
        int                exp_lat;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        z;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    dot_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .op_valid(op_valid), .op_ready(op_ready),
        .a_data(a_data), .b_data(b_data),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z),
        .result(result), .result_z(result_z), .done(done), .busy(busy)
`ifdef DOT_SEQ_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU the sequencer drives.
    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_out = alu_in1 + alu_in2;
            ALU_SUB:  alu_out = alu_in1 - alu_in2;
            ALU_MUL:  alu_out = alu_in1 * alu_in2;
            ALU_DIV:  alu_out = (alu_in2 == 16'd0) ? 16'hFFFF : alu_in1 / alu_in2;
            default:  alu_out = alu_in1;
        endcase
        alu_z = (alu_out == 16'd0);
    end

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(input int l, input logic [63:0] as, input logic [63:0] bs,
                                input int gi, input int gl, input bit sp,
                                input logic [15:0] r, input logic z, input int lat);
        vec_t v;
        v.len = l; v.a = as; v.b = bs; v.gap_idx = gi; v.gap_len = gl; v.spam = sp;
        v.exp_res = r; v.exp_z = z; v.exp_lat = lat;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one job from the table; expected values go through the scoreboard.
    task automatic run_vec(input vec_t v, input string nm);
        exp_t e;
        int c, idx, stall;
        bit got, saw_ready, offered;
        logic [15:0] held;
        e.res = v.exp_res; e.z = v.exp_z; e.lat = v.exp_lat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; len = LEN_W'(v.len); op_valid = 1'b1;
        a_data = v.a[0]; b_data = v.b[0];
        tick();
        if (v.spam) len = LEN_W'(1); else start = 1'b0;
        c = 1; idx = 0; stall = 0; got = 0; saw_ready = 0; offered = 0;
        while (!got && c <= TIMEOUT) begin
            if (op_ready) saw_ready = 1;
            if (done) begin
                got = 1;
            end else begin
                if (alu_op == ALU_MUL && idx > 0 && idx <= 4)
                    check($sformatf("%s mul operand A%0d", nm, idx - 1), 32'(alu_in1), 32'(v.a[2'(idx - 1)]));
                offered = 0;
                op_valid = 1'b1;
                if (op_ready && idx < 4) begin
                    if (idx == v.gap_idx && stall < v.gap_len) begin
                        op_valid = 1'b0;
                        stall++;
                    end else begin
                        a_data = v.a[2'(idx)];
                        b_data = v.b[2'(idx)];
                        offered = 1;
                    end
                end
                tick();
                c++;
                if (offered) idx++;
            end
        end
        start = 1'b0; op_valid = 1'b0;
        check({nm, " done seen"}, 32'(got), 32'd1);
        check({nm, " scoreboard nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({nm, " result"}, 32'(result), 32'(e.res));
            check({nm, " result_z"}, 32'(result_z), 32'(e.z));
            check({nm, " latency"}, 32'(c), 32'(e.lat));
            check({nm, " busy at done"}, 32'(busy), 32'd1);
            if (v.len == 0) check({nm, " op_ready never"}, 32'(saw_ready), 32'd0);
            held = result;
            tick();
            check({nm, " done one cycle"}, 32'(done), 32'd0);
            tick();
            check({nm, " idle after"}, 32'(busy), 32'd0);
            tick();
            check({nm, " result held"}, 32'(result), 32'(held));
        end
    endtask

    initial begin
        bit seen;
        reset = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0;
        a_data = '0; b_data = '0;
`ifdef DOT_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        vecs[0] = mk(3, {16'd0, 16'd5, 16'd3, 16'd1}, {16'd0, 16'd6, 16'd4, 16'd2}, 99, 0, 0, 16'd44, 1'b0, 10);
        vecs[1] = mk(0, 64'd0, 64'd0, 99, 0, 0, 16'd0, 1'b1, 1);
        vecs[2] = mk(1, {48'd0, 16'd256}, {48'd0, 16'd256}, 99, 0, 0, 16'd0, 1'b1, 4);
        vecs[3] = mk(2, {32'd0, 16'd2, 16'd7}, {32'd0, 16'd5, 16'd3}, 1, 5, 0, 16'd31, 1'b0, 12);
        vecs[4] = mk(4, {16'h8000, 16'hFFFF, 16'd300, 16'd100}, {16'd2, 16'd2, 16'd400, 16'd200},
                     99, 0, 1, 16'd8926, 1'b0, 13);
        vecs[5] = mk(2, {32'd0, 16'd0, 16'd3}, {32'd0, 16'd9, 16'd0}, 0, 2, 0, 16'd0, 1'b1, 9);
        vecs[6] = mk(1, {48'd0, 16'd4}, {48'd0, 16'd4}, 99, 0, 0, 16'd16, 1'b0, 4);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset op_ready", 32'(op_ready), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset result_z", 32'(result_z), 32'd0);
        check("reset alu_op", 32'(alu_op), 32'(ALU_PASS));
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the ADD of element 2 of a len=4 job.
        @(negedge clk);
        start = 1'b1; len = LEN_W'(4); op_valid = 1'b1; a_data = 16'd3; b_data = 16'd3;
        tick();
        start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        check("rst job in ADD", 32'(alu_op), 32'(ALU_ADD));
        reset = 1'b1;
        tick();
        reset = 1'b0; op_valid = 1'b0;
        check("rst job busy", 32'(busy), 32'd0);
        check("rst job op_ready", 32'(op_ready), 32'd0);
        check("rst job result", 32'(result), 32'd0);
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            if (done) seen = 1;
            tick();
        end
        check("rst job no done", 32'(seen), 32'd0);
        run_vec(vecs[6], "after reset");

`ifdef DOT_SEQ_ABORT_EN
        // Abort while in MUL keeps the previous result.
        @(negedge clk);
        start = 1'b1; len = LEN_W'(2); op_valid = 1'b1; a_data = 16'd9; b_data = 16'd9;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10 && alu_op != ALU_MUL; c++) tick();
        check("abort in MUL", 32'(alu_op), 32'(ALU_MUL));
        abort = 1'b1;
        tick();
        abort = 1'b0; op_valid = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort op_ready", 32'(op_ready), 32'd0);
        check("abort result kept", 32'(result), 32'd16);
        check("abort result_z kept", 32'(result_z), 32'd0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) seen = 1;
            tick();
        end
        check("abort no done", 32'(seen), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
